rtc_spi_bridge: RTL

Consumes the registered RTC cycle request from the $DC0000 decode/punt stage and forwards each CPU access to the on-board MCU over SPI. It latches the cycle, raises a request line to the MCU, and serves one 16-bit SPI slave frame carrying command and data. It then returns the read data and a completion strobe that the decode stage turns into DSACK. All SPI pins are oversampled in the CPU clock domain.

---
 rtl/rtc_spi_bridge.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/rtc_spi_bridge.sv
// rtc_spi_bridge: carries one latched RTC CPU cycle to the MCU as a single
// 16-bit mode-0 SPI slave frame, then returns read data and a completion
// strobe. SPI pins are oversampled on CLKCPU_A, which is the only clock.
module rtc_spi_bridge #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       CLKCPU_A,
  input  logic       RESET,
  input  logic       CYCLE_REQ,
  input  logic       RW,
  input  logic [5:0] A,
  input  logic [7:0] D_IN,
  output logic [7:0] D_OUT,
  output logic       D_OE,
  output logic       CYCLE_DONE,
  output logic       MCU_REQ,
  input  logic       SPI_NSS,
  input  logic       SPI_CK,
  input  logic       SPI_MOSI,
  output logic       SPI_MISO
);

  localparam int            TW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  // S_DRAIN waits out an MCU frame that was in flight when the CPU aborted.
  typedef enum logic [2:0] {
    S_IDLE,
    S_PENDING,
    S_SHIFT,
    S_DRAIN,
    S_ACK
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] nss_sync_q, ck_sync_q, mosi_sync_q;
  logic                   nss_prev_q, ck_prev_q;
  logic                   nss_s, ck_s, mosi_s;
  logic                   nss_fall, nss_rise, ck_rise, ck_fall;
  logic [4:0]             bit_cnt_q;
  logic [7:0]             rx_q;
  logic [15:0]            tx_q;
  logic [15:0]            tx_frame_d;
  logic [TW-1:0]          to_cnt_q;
  logic                   timeout_d;
  logic                   rw_q;
  logic [5:0]             a_q;
  logic [7:0]             wd_q;
  logic                   mcu_req_q, cycle_done_q, d_oe_q;
  logic [7:0]             d_out_q;

  // Synchronise the SPI pins and keep the previous level for edge detection.
  always_ff @(posedge CLKCPU_A) begin
    if (RESET) begin
      // NOTE: NSS idles high, so its chain resets to 1; resetting it to 0
      // would manufacture a chip-select edge on the first clocks after reset.
      nss_sync_q  <= '1;
      ck_sync_q   <= '0;
      mosi_sync_q <= '0;
      nss_prev_q  <= 1'b1;
      ck_prev_q   <= 1'b0;
    end else begin
      nss_sync_q  <= {nss_sync_q[SYNC_STAGES-2:0], SPI_NSS};
      ck_sync_q   <= {ck_sync_q[SYNC_STAGES-2:0], SPI_CK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
      nss_prev_q  <= nss_sync_q[SYNC_STAGES-1];
      ck_prev_q   <= ck_sync_q[SYNC_STAGES-1];
    end
  end

  assign nss_s    = nss_sync_q[SYNC_STAGES-1];
  assign ck_s     = ck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign nss_fall = ~nss_s & nss_prev_q;
  assign nss_rise = nss_s & ~nss_prev_q;
  assign ck_rise  = ck_s & ~ck_prev_q;
  assign ck_fall  = ~ck_s & ck_prev_q;

  // Frame image rebuilt from the latched cycle when a short frame is retried.
  assign tx_frame_d = {rw_q, 1'b1, a_q, (rw_q ? 8'h00 : wd_q)};
  assign timeout_d  = (to_cnt_q == TO_LAST);

  // Count SCK rises since chip select and shift MOSI in; only the last
  // eight bits are kept because MOSI byte0 carries nothing.
  always_ff @(posedge CLKCPU_A) begin
    if (RESET) begin
      bit_cnt_q <= '0;
      rx_q      <= '0;
    end else begin
      if (nss_fall) begin
        bit_cnt_q <= '0;
      end else if (ck_rise && (bit_cnt_q != 5'd31)) begin
        bit_cnt_q <= bit_cnt_q + 5'd1;
      end
      if (ck_rise) begin
        rx_q <= {rx_q[6:0], mosi_s};
      end
    end
  end

  // Cycle FSM with registered outputs and the MISO shift register.
  always_ff @(posedge CLKCPU_A) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      tx_q         <= '0;
      to_cnt_q     <= '0;
      rw_q         <= 1'b0;
      a_q          <= '0;
      wd_q         <= '0;
      mcu_req_q    <= 1'b0;
      cycle_done_q <= 1'b0;
      d_oe_q       <= 1'b0;
      d_out_q      <= '0;
    end else begin
      // Mode 0: the MCU samples on the rise, so the next bit moves on the fall.
      // Later assignments in the case below override this default shift.
      if (ck_fall) begin
        tx_q <= {tx_q[14:0], 1'b0};
      end

      case (state_q)
        S_IDLE: begin
          if (CYCLE_REQ) begin
            rw_q      <= RW;
            a_q       <= A;
            wd_q      <= D_IN;
            tx_q      <= {RW, 1'b1, A, (RW ? 8'h00 : D_IN)};
            mcu_req_q <= 1'b1;
            to_cnt_q  <= '0;
            state_q   <= S_PENDING;
          end
        end

        S_PENDING: begin
          if (!CYCLE_REQ) begin
            mcu_req_q <= 1'b0;
            tx_q      <= '0;
            state_q   <= S_IDLE;
          end else if (timeout_d) begin
            d_out_q      <= 8'hFF;
            mcu_req_q    <= 1'b0;
            cycle_done_q <= 1'b1;
            d_oe_q       <= rw_q;
            tx_q         <= '0;
            state_q      <= S_ACK;
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
            if (nss_fall) begin
              state_q <= S_SHIFT;
            end
          end
        end

        S_SHIFT: begin
          if (!CYCLE_REQ) begin
            mcu_req_q <= 1'b0;
            tx_q      <= '0;
            state_q   <= nss_rise ? S_IDLE : S_DRAIN;
          end else if (nss_rise && (bit_cnt_q == 5'd16)) begin
            // A complete frame takes priority over a timeout in the same clock.
            if (rw_q) begin
              d_out_q <= rx_q;
            end
            mcu_req_q    <= 1'b0;
            cycle_done_q <= 1'b1;
            d_oe_q       <= rw_q;
            tx_q         <= '0;
            state_q      <= S_ACK;
          end else if (timeout_d) begin
            d_out_q      <= 8'hFF;
            mcu_req_q    <= 1'b0;
            cycle_done_q <= 1'b1;
            d_oe_q       <= rw_q;
            tx_q         <= '0;
            state_q      <= S_ACK;
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
            if (nss_rise) begin
              tx_q    <= tx_frame_d;
              state_q <= S_PENDING;
            end
          end
        end

        S_DRAIN: begin
          if (nss_s) begin
            tx_q    <= '0;
            state_q <= S_IDLE;
          end
        end

        S_ACK: begin
          if (!CYCLE_REQ) begin
            cycle_done_q <= 1'b0;
            d_oe_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign D_OUT      = d_out_q;
  assign D_OE       = d_oe_q;
  assign CYCLE_DONE = cycle_done_q;
  assign MCU_REQ    = mcu_req_q;
  assign SPI_MISO   = tx_q[15];

endmodule
